// File: rtl/approx_mul_err_monitor.sv
// Error-metric engine for approximate multipliers.
// Takes (a, b, apprx) samples, forms the exact product, and accumulates
// error count, zero-product count, signed/absolute error-distance sums and
// the maximum error distance over a run of num_samples samples.
module approx_mul_err_monitor #(
  parameter int W     = 8,
  parameter int CNT_W = 32,
  parameter int ACC_W = 2 * W + CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic [2*W-1:0]     apprx,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   zero_cnt,
  output logic [ACC_W-1:0]   sum_abs_ed,
  output logic [ACC_W:0]     sum_ed,
  output logic [2*W-1:0]     max_ed
);

  localparam int PW = 2 * W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Saturating increment of a sample counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    logic [CNT_W-1:0] r;
    if (en && (c != {CNT_W{1'b1}})) begin
      r = c + CNT_ONE;
    end else begin
      r = c;
    end
    return r;
  endfunction

  // Saturating unsigned accumulate of an absolute error distance.
  function automatic logic [ACC_W-1:0] sat_add_u(input logic [ACC_W-1:0] acc,
                                                 input logic [PW-1:0]    v);
    logic [ACC_W:0]   s;
    logic [ACC_W-1:0] r;
    s = {1'b0, acc} + {{(ACC_W+1-PW){1'b0}}, v};
    if (s[ACC_W]) begin
      r = {ACC_W{1'b1}};
    end else begin
      r = s[ACC_W-1:0];
    end
    return r;
  endfunction

  // Saturating two's-complement accumulate of a signed error distance.
  function automatic logic [ACC_W:0] sat_add_s(input logic [ACC_W:0] acc,
                                               input logic [PW:0]    d);
    logic [ACC_W+1:0] s;
    logic [ACC_W:0]   r;
    s = {acc[ACC_W], acc} + {{(ACC_W+1-PW){d[PW]}}, d};
    if (s[ACC_W+1] != s[ACC_W]) begin
      if (s[ACC_W+1]) begin
        r = {1'b1, {ACC_W{1'b0}}};
      end else begin
        r = {1'b0, {ACC_W{1'b1}}};
      end
    end else begin
      r = s[ACC_W:0];
    end
    return r;
  endfunction

  state_t             state_q;
  logic [CNT_W-1:0]   num_q;
  logic [CNT_W-1:0]   acc_cnt_q;
  logic               in_ready_q;
  logic               busy_q;
  logic               done_q;

  logic               s1_v_q;
  logic [PW-1:0]      s1_exact_q;
  logic [PW-1:0]      s1_apprx_q;

  logic               s2_v_q;
  logic [PW:0]        s2_diff_q;
  logic [PW-1:0]      s2_abs_q;
  logic               s2_zero_q;
  logic               s2_err_q;

  logic [CNT_W-1:0]   sample_cnt_q;
  logic [CNT_W-1:0]   err_cnt_q;
  logic [CNT_W-1:0]   zero_cnt_q;
  logic [ACC_W-1:0]   sum_abs_q;
  logic [ACC_W:0]     sum_ed_q;
  logic [PW-1:0]      max_ed_q;

  logic               accept_s;
  logic               start_acc_s;
  logic [PW-1:0]      exact_d;
  logic [PW:0]        diff_d;
  logic [PW:0]        neg_d;
  logic [PW-1:0]      abs_d;

  assign accept_s    = in_valid & in_ready_q;
  assign start_acc_s = start & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign exact_d     = {{W{1'b0}}, a} * {{W{1'b0}}, b};

  // Error distance of the sample held in stage 1.
  always_comb begin
    diff_d = {1'b0, s1_exact_q} - {1'b0, s1_apprx_q};
    neg_d  = {(PW+1){1'b0}} - diff_d;
    if (diff_d[PW]) begin
      abs_d = neg_d[PW-1:0];
    end else begin
      abs_d = diff_d[PW-1:0];
    end
  end

  // Run control: accept counting, drain of the pipeline and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      num_q      <= {CNT_W{1'b0}};
      acc_cnt_q  <= {CNT_W{1'b0}};
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            num_q     <= num_samples;
            acc_cnt_q <= {CNT_W{1'b0}};
            if (num_samples == {CNT_W{1'b0}}) begin
              state_q    <= S_DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              state_q    <= S_RUN;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              done_q     <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (accept_s) begin
            acc_cnt_q <= acc_cnt_q + CNT_ONE;
            if (acc_cnt_q == (num_q - CNT_ONE)) begin
              state_q    <= S_DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          // Both stages empty: the last sample has reached the results.
          if (!s1_v_q && !s2_v_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: exact product and approximate product of the accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s1_exact_q <= {PW{1'b0}};
      s1_apprx_q <= {PW{1'b0}};
    end else begin
      s1_v_q <= accept_s;
      if (accept_s) begin
        s1_exact_q <= exact_d;
        s1_apprx_q <= apprx;
      end
    end
  end

  // Stage 2: signed and absolute error distance plus per-sample flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v_q    <= 1'b0;
      s2_diff_q <= {(PW+1){1'b0}};
      s2_abs_q  <= {PW{1'b0}};
      s2_zero_q <= 1'b0;
      s2_err_q  <= 1'b0;
    end else begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_diff_q <= diff_d;
        s2_abs_q  <= abs_d;
        s2_zero_q <= (s1_exact_q == {PW{1'b0}});
        s2_err_q  <= (diff_d != {(PW+1){1'b0}});
      end
    end
  end

  // Result accumulators: cleared by an accepted start, updated per sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt_q <= {CNT_W{1'b0}};
      err_cnt_q    <= {CNT_W{1'b0}};
      zero_cnt_q   <= {CNT_W{1'b0}};
      sum_abs_q    <= {ACC_W{1'b0}};
      sum_ed_q     <= {(ACC_W+1){1'b0}};
      max_ed_q     <= {PW{1'b0}};
    end else if (start_acc_s) begin
      sample_cnt_q <= {CNT_W{1'b0}};
      err_cnt_q    <= {CNT_W{1'b0}};
      zero_cnt_q   <= {CNT_W{1'b0}};
      sum_abs_q    <= {ACC_W{1'b0}};
      sum_ed_q     <= {(ACC_W+1){1'b0}};
      max_ed_q     <= {PW{1'b0}};
    end else if (s2_v_q) begin
      sample_cnt_q <= sat_inc(sample_cnt_q, 1'b1);
      err_cnt_q    <= sat_inc(err_cnt_q, s2_err_q);
      zero_cnt_q   <= sat_inc(zero_cnt_q, s2_zero_q);
      sum_abs_q    <= sat_add_u(sum_abs_q, s2_abs_q);
      sum_ed_q     <= sat_add_s(sum_ed_q, s2_diff_q);
      if (s2_abs_q > max_ed_q) begin
        max_ed_q <= s2_abs_q;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign zero_cnt   = zero_cnt_q;
  assign sum_abs_ed = sum_abs_q;
  assign sum_ed     = sum_ed_q;
  assign max_ed     = max_ed_q;

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Scoreboard bench for approx_mul_err_monitor: the driver pushes the
// expected end-of-run results, a monitor pops them when done rises.
module tb_approx_mul_err_monitor;

  localparam int W     = 8;
  localparam int CNT_W = 32;
  localparam int ACC_W = 2 * W + CNT_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [CNT_W-1:0]   num_samples;
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       a;
  logic [W-1:0]       b;
  logic [2*W-1:0]     apprx;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   sample_cnt;
  logic [CNT_W-1:0]   err_cnt;
  logic [CNT_W-1:0]   zero_cnt;
  logic [ACC_W-1:0]   sum_abs_ed;
  logic [ACC_W:0]     sum_ed;
  logic [2*W-1:0]     max_ed;

  approx_mul_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .apprx(apprx),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .zero_cnt(zero_cnt), .sum_abs_ed(sum_abs_ed), .sum_ed(sum_ed), .max_ed(max_ed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint sc, ec, zc, sabs, sed, mx;
    int     done_cyc;
  } exp_t;

  exp_t   q[$];
  int     ma[$], mb[$], mp[$];
  int     last_acc;
  int     start_cyc;
  int     checks = 0;
  int     errors = 0;
  bit     busy_seen = 1'b0;

  always @(negedge clk) if (busy) busy_seen = 1'b1;

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, longint'(in_ready), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_sample_cnt"}, longint'(sample_cnt), 0);
    chk({tag, "_err_cnt"}, longint'(err_cnt), 0);
    chk({tag, "_zero_cnt"}, longint'(zero_cnt), 0);
    chk({tag, "_sum_abs_ed"}, longint'(sum_abs_ed), 0);
    chk({tag, "_sum_ed"}, longint'($signed(sum_ed)), 0);
    chk({tag, "_max_ed"}, longint'(max_ed), 0);
  endtask

  task automatic do_start(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    num_samples = n;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    ma.delete(); mb.delete(); mp.delete();
  endtask

  task automatic send(input int av, input int bv, input int pv, input int gap, input bit chk_gap);
    bit ok;
    in_valid = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      if (chk_gap) chk("in_ready_gap", longint'(in_ready), 1);
      @(posedge clk); #1;
    end
    a = av[W-1:0];
    b = bv[W-1:0];
    apprx = pv[2*W-1:0];
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      chk("accept_timeout", longint'(ok), 1);
    end else begin
      last_acc = cyc;
      ma.push_back(av); mb.push_back(bv); mp.push_back(pv);
    end
  endtask

  // Reference: error metrics straight from the sample list.
  task automatic push_exp();
    exp_t   e;
    longint ex, d, ad;
    longint acc_max = (longint'(1) <<< ACC_W) - 1;
    e = '{0, 0, 0, 0, 0, 0, 0};
    foreach (ma[i]) begin
      ex = longint'(ma[i]) * longint'(mb[i]);
      d  = ex - longint'(mp[i]);
      ad = (d < 0) ? -d : d;
      e.sc++;
      if (d != 0) e.ec++;
      if (ex == 0) e.zc++;
      e.sabs = (e.sabs + ad > acc_max) ? acc_max : e.sabs + ad;
      e.sed += d;
      if (ad > e.mx) e.mx = ad;
    end
    e.done_cyc = (ma.size() == 0) ? start_cyc : last_acc + 3;
    q.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      chk("done_timeout", longint'(q.size()), 0);
      q.delete();
    end
    #1;
  endtask

  task automatic end_run();
    push_exp();
    wait_done();
  endtask

  // Monitor: compare the final results each time done rises.
  initial begin
    bit   prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && !prev) begin
        if (q.size() == 0) begin
          chk("unexpected_done", longint'(done), 0);
        end else begin
          e = q.pop_front();
          chk("done_latency", longint'(cyc), longint'(e.done_cyc));
          chk("sample_cnt", longint'(sample_cnt), e.sc);
          chk("err_cnt", longint'(err_cnt), e.ec);
          chk("zero_cnt", longint'(zero_cnt), e.zc);
          chk("sum_abs_ed", longint'(sum_abs_ed), e.sabs);
          chk("sum_ed", longint'($signed(sum_ed)), e.sed);
          chk("max_ed", longint'(max_ed), e.mx);
          chk("busy_in_done", longint'(busy), 0);
        end
      end
      prev = done;
    end
  end

  initial begin
    int n, av, bv, ex, pv, mode;
    rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
    a = '0; b = '0; apprx = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    // Exact samples, including a zero product.
    do_start(4);
    send(3, 5, 15, 0, 1'b0);
    send(255, 255, 65025, 0, 1'b0);
    send(0, 7, 0, 0, 1'b0);
    send(10, 10, 100, 0, 1'b0);
    end_run();

    // Positive and negative error distances.
    do_start(3);
    send(16, 16, 250, 0, 1'b0);
    send(200, 3, 610, 0, 1'b0);
    send(1, 1, 1, 0, 1'b0);
    end_run();

    // Gaps between samples, then an extra sample that must be refused.
    do_start(2);
    send(7, 9, 60, 5, 1'b1);
    send(12, 12, 150, 5, 1'b1);
    push_exp();
    a = 8'd100; b = 8'd100; apprx = 16'd0; in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("extra_refused", longint'(in_ready), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_done();

    // start during RUN is ignored.
    do_start(3);
    send(4, 4, 17, 0, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; num_samples = 1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_ignored_start", longint'(busy), 1);
    send(5, 6, 28, 1, 1'b1);
    send(9, 9, 81, 0, 1'b0);
    end_run();

    // Reset in the middle of a run.
    do_start(5);
    send(20, 20, 300, 0, 1'b0);
    send(30, 30, 800, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    do_start(1);
    send(2, 2, 5, 0, 1'b0);
    end_run();

    // Empty run from IDLE.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    busy_seen = 1'b0;
    do_start(0);
    end_run();
    chk("zero_run_busy_seen", longint'(busy_seen), 0);

    // Randomised runs.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 6);
      do_start(n);
      for (int k = 0; k < n; k++) begin
        av = $urandom_range(0, 255);
        bv = $urandom_range(0, 255);
        ex = av * bv;
        mode = $urandom_range(0, 3);
        if (mode == 0) pv = ex;
        else if (mode == 3) pv = $urandom_range(0, 65535);
        else pv = ex + int'($urandom_range(0, 16)) - 8;
        if (pv < 0) pv = 0;
        if (pv > 65535) pv = 65535;
        send(av, bv, pv, $urandom_range(0, 3), 1'b1);
      end
      end_run();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
